// File: rtl/nibble_load_sequencer_pkg.sv
// Shared definitions for the nibble load sequencer.
//   - NIB_W: width of one nibble
//   - state encoding for the sequencing FSM (IDLE / STROBE / GAP)
//   - clog2 helper used to size index and hold counters
package nibble_load_sequencer_pkg;

    localparam int unsigned NIB_W = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STROBE = 2'd1;
    localparam logic [1:0] ST_GAP    = 2'd2;

    typedef enum logic [1:0] {
        StIdle   = ST_IDLE,
        StStrobe = ST_STROBE,
        StGap    = ST_GAP
    } state_e;

    // Smallest r with 2**r >= value; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/nibble_load_sequencer_nibble_select.sv
// nibble_select: combinational NIBBLES:1 mux picking one nibble of a word.
// Ports:
//   word_i  in   NIB_W*NIBBLES  word, nibble 0 = bits [3:0]
//   idx_i   in   IDX_W          nibble index
//   nib_o   out  NIB_W          selected nibble (0 for out-of-range index)
module nibble_select
    import nibble_load_sequencer_pkg::*;
#(
    parameter int unsigned NIBBLES = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NIB_W*NIBBLES-1:0] word_i,
    input  logic [IDX_W-1:0]         idx_i,
    output logic [NIB_W-1:0]         nib_o
);

    always_comb begin
        nib_o = '0;
        for (int i = 0; i < int'(NIBBLES); i++) begin
            if (idx_i == IDX_W'(i)) begin
                nib_o = word_i[i*NIB_W +: NIB_W];
            end
        end
    end

endmodule

// File: rtl/nibble_load_sequencer.sv
// nibble_load_sequencer: feeds a 25LS2519 quad register one nibble per strobe.
// A word accepted over valid/ready is shadowed and presented nibble by nibble
// with an active-low load strobe, HOLD_CYCLES cycles apart.
// Optional feature macro: NIBBLE_SEQ_PARITY_EN adds the registered odd-parity
// output nib_par_o.
// Ports:
//   clk_i            in   clock, rising edge
//   reset_i          in   asynchronous clear, active-high
//   word_in_i        in   word to load, nibble 0 = bits [3:0]
//   word_inv_i       in   INV value for the whole word
//   word_valid_i     in   word_in_i / word_inv_i valid
//   word_ready_o     out  sequencer can accept a word
//   nib_out_o        out  current nibble (I3..I0)
//   nib_inv_o        out  INV
//   nib_clk_enb_n_o  out  active-low load strobe (CLK_ENB_N)
//   nib_idx_o        out  index of nibble on nib_out_o
//   busy_o           out  word in progress
//   nib_par_o        out  odd parity of nib_out_o (macro only)
module nibble_load_sequencer
    import nibble_load_sequencer_pkg::*;
#(
    parameter int unsigned NIBBLES     = 4,
    parameter int unsigned HOLD_CYCLES = 1,
    parameter int unsigned IDX_W       = clog2(NIBBLES)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [NIB_W*NIBBLES-1:0] word_in_i,
    input  logic                     word_inv_i,
    input  logic                     word_valid_i,
    output logic                     word_ready_o,
    output logic [NIB_W-1:0]         nib_out_o,
    output logic                     nib_inv_o,
    output logic                     nib_clk_enb_n_o,
    output logic [IDX_W-1:0]         nib_idx_o,
`ifdef NIBBLE_SEQ_PARITY_EN
    output logic                     nib_par_o,
`endif
    output logic                     busy_o
);

    localparam int unsigned WORD_W = NIB_W * NIBBLES;
    localparam int unsigned CNT_W  = (clog2(HOLD_CYCLES) > 0) ? clog2(HOLD_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e             state_q, state_d;
    logic [WORD_W-1:0]  shadow_q, shadow_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NIB_W-1:0]   nib_q, nib_d;
    logic               inv_q, inv_d;
    logic               enb_n_q, enb_n_d;
    logic [NIB_W-1:0]   sel_nib;
    logic               load_nib;

    // Mux the next-state shadow/index so the first nibble is registered on
    // the same edge that accepts the word.
    nibble_select #(
        .NIBBLES (NIBBLES),
        .IDX_W   (IDX_W)
    ) u_nibble_select (
        .word_i (shadow_d),
        .idx_i  (idx_d),
        .nib_o  (sel_nib)
    );

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        inv_d    = inv_q;
        enb_n_d  = 1'b1;
        load_nib = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (word_valid_i) begin
                    shadow_d = word_in_i;
                    inv_d    = word_inv_i;
                    idx_d    = '0;
                    load_nib = 1'b1;
                    enb_n_d  = 1'b0;
                    state_d  = StStrobe;
                end
            end
            StStrobe: begin
                if (idx_q == LAST_IDX) begin
                    state_d = StIdle;
                end else if (HOLD_CYCLES > 1) begin
                    // GAP lasts HOLD_CYCLES-1 cycles; counter runs down to 0.
                    cnt_d   = CNT_W'(HOLD_CYCLES - 2);
                    state_d = StGap;
                end else begin
                    idx_d    = idx_q + IDX_W'(1);
                    load_nib = 1'b1;
                    enb_n_d  = 1'b0;
                end
            end
            StGap: begin
                if (cnt_q == '0) begin
                    idx_d    = idx_q + IDX_W'(1);
                    load_nib = 1'b1;
                    enb_n_d  = 1'b0;
                    state_d  = StStrobe;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        nib_d = load_nib ? sel_nib : nib_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            shadow_q <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            nib_q    <= '0;
            inv_q    <= 1'b0;
            enb_n_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            nib_q    <= nib_d;
            inv_q    <= inv_d;
            enb_n_q  <= enb_n_d;
        end
    end

`ifdef NIBBLE_SEQ_PARITY_EN
    logic par_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            par_q <= 1'b1;
        end else begin
            par_q <= ~^nib_d;
        end
    end

    assign nib_par_o = par_q;
`endif

    assign word_ready_o    = (state_q == StIdle);
    assign busy_o          = (state_q != StIdle);
    assign nib_out_o       = nib_q;
    assign nib_inv_o       = inv_q;
    assign nib_clk_enb_n_o = enb_n_q;
    assign nib_idx_o       = idx_q;

endmodule
